// File: rtl/cu_memfetch_if.sv
// cu_memfetch_if: fetch request/response and program-load signals between the CU and cu_memfetch
//   master (CU side): drives memfetch_start, fetch_pc, IF_stall, load_en, load_addr, load_data
//   slave (cu_memfetch): drives Fetch_ready, fetch_instr, fetch_pc_out, fetch_busy,
//                        misaligned_err, range_err
interface cu_memfetch_if #(
    parameter int IMEM_DEPTH = 128
);
    logic                          memfetch_start;
    logic [31:0]                   fetch_pc;
    logic                          IF_stall;
    logic                          load_en;
    logic [$clog2(IMEM_DEPTH)-1:0] load_addr;
    logic [31:0]                   load_data;
    logic                          Fetch_ready;
    logic [31:0]                   fetch_instr;
    logic [31:0]                   fetch_pc_out;
    logic                          fetch_busy;
    logic                          misaligned_err;
    logic                          range_err;

    modport master (
        output memfetch_start, fetch_pc, IF_stall, load_en, load_addr, load_data,
        input  Fetch_ready, fetch_instr, fetch_pc_out, fetch_busy, misaligned_err, range_err
    );
    modport slave (
        input  memfetch_start, fetch_pc, IF_stall, load_en, load_addr, load_data,
        output Fetch_ready, fetch_instr, fetch_pc_out, fetch_busy, misaligned_err, range_err
    );
endinterface

// File: rtl/cu_memfetch.sv
// cu_memfetch: instruction-fetch responder returning one IMEM word per CU fetch request
//   soc_clk  clock, all state changes on the rising edge
//   reset    asynchronous active-high reset (memory contents are kept)
//   bus      slave side of cu_memfetch_if: start/pc/stall request, program-load port,
//            Fetch_ready pulse with fetch_instr/fetch_pc_out, busy flag, error pulses
//   Optional: define CU_IF_PREFETCH_EN to add a one-entry next-line buffer so that a
//   fetch of the word following the previous fetch completes in one cycle.
module cu_memfetch #(
    parameter int IMEM_DEPTH   = 128,
    parameter int READ_LATENCY = 2
) (
    input logic          soc_clk,
    input logic          reset,
    cu_memfetch_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(READ_LATENCY) + 1;
    localparam logic [31:0] BYTES = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [IMEM_DEPTH];
    logic [31:0]   pc_q, instr_q, pc_out_q, req_data, wait_data, imm_data;
    logic [CW-1:0] cnt;
    logic          mis, oor, accept, hit, imm, last, mis_q, rng_q;

    // Write-first: a load to the word being read on the same edge is forwarded.
    assign req_data  = bus.load_en && bus.load_addr == bus.fetch_pc[AW+1:2] ? bus.load_data : mem[bus.fetch_pc[AW+1:2]];
    assign wait_data = bus.load_en && bus.load_addr == pc_q[AW+1:2] ? bus.load_data : mem[pc_q[AW+1:2]];

`ifdef CU_IF_PREFETCH_EN
    logic        pf_valid;
    logic [31:0] pf_tag, pf_data, nxt_pc, nxt_data;
    assign nxt_pc   = pc_q + 32'd4;
    assign nxt_data = bus.load_en && bus.load_addr == nxt_pc[AW+1:2] ? bus.load_data : mem[nxt_pc[AW+1:2]];
    assign hit      = pf_valid && bus.fetch_pc == pf_tag;
    assign imm_data = hit ? (bus.load_en && bus.load_addr == pf_tag[AW+1:2] ? bus.load_data : pf_data) : req_data;
    // Refill with the next line after every completed fetch; a load to the tagged word drops it.
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_tag   <= '0;
            pf_data  <= '0;
        end else if (state == DONE && nxt_pc < BYTES) begin
            pf_valid <= 1'b1;
            pf_tag   <= nxt_pc;
            pf_data  <= nxt_data;
        end else if (bus.load_en && bus.load_addr == pf_tag[AW+1:2]) begin
            pf_valid <= 1'b0;
        end
    end
`else
    assign hit      = 1'b0;
    assign imm_data = req_data;
`endif

    always_ff @(posedge soc_clk)
        if (bus.load_en)
            mem[bus.load_addr] <= bus.load_data;

    always_ff @(posedge soc_clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;

    // imm: result available on the accept edge (buffer hit or single-cycle latency).
    // last: final WAIT cycle, memory is read on this edge.
    always_comb begin
        mis      = bus.fetch_pc[1:0] != 2'b00;
        oor      = bus.fetch_pc >= BYTES;
        accept   = state == IDLE && bus.memfetch_start && !mis && !oor;
        imm      = accept && (hit || READ_LATENCY == 1);
        last     = state == WAIT && cnt == CW'(1);
        state_nx = state;
        if (accept)
            state_nx = imm ? (bus.IF_stall ? HOLD : DONE) : WAIT;
        if (last || state == HOLD)
            state_nx = bus.IF_stall ? HOLD : DONE;
        if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            mis_q    <= 1'b0;
            rng_q    <= 1'b0;
        end else begin
            mis_q <= state == IDLE && bus.memfetch_start && mis;
            rng_q <= state == IDLE && bus.memfetch_start && !mis && oor;
            if (accept) begin
                pc_q <= bus.fetch_pc;
                cnt  <= CW'(READ_LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (imm) begin
                instr_q  <= imm_data;
                pc_out_q <= bus.fetch_pc;
            end else if (last) begin
                instr_q  <= wait_data;
                pc_out_q <= pc_q;
            end
        end
    end

    assign bus.Fetch_ready    = state == DONE;
    assign bus.fetch_busy     = state != IDLE;
    assign bus.fetch_instr    = instr_q;
    assign bus.fetch_pc_out   = pc_out_q;
    assign bus.misaligned_err = mis_q;
    assign bus.range_err      = rng_q;
endmodule

// File: tb/tb_cu_memfetch.sv
// tb_cu_memfetch: directed bench for cu_memfetch with a transaction-level reference model
module tb_cu_memfetch;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam logic [31:0] BYTES = 32'(4 * DEPTH);

    logic soc_clk = 1'b0;
    logic reset   = 1'b1;

    cu_memfetch_if #(.IMEM_DEPTH(DEPTH)) bus ();
    cu_memfetch #(.IMEM_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .soc_clk(soc_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 soc_clk = ~soc_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch accepted at edge c has its word read from memory at
    // edge c+LAT-1 (edge c on a next-line hit); Fetch_ready follows the first edge
    // from then on where IF_stall is low, and the block is busy until the edge after.
    logic [31:0] m [DEPTH];
    int          cyc = 0;
    int          due = 0;
    logic        busy = 0, have = 0, e_rdy = 0, e_mis = 0, e_rng = 0, pvalid = 0, hit = 0;
    logic [31:0] mpc = 0, e_instr = 0, e_pc = 0, ptag = 0;

    always @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            busy = 0; have = 0; e_rdy = 0; e_mis = 0; e_rng = 0; pvalid = 0;
            e_instr = 0; e_pc = 0;
        end else begin
            cyc++;
            hit   = pvalid && bus.fetch_pc == ptag;
            e_mis = 0;
            e_rng = 0;
            if (bus.load_en) begin
                m[bus.load_addr] = bus.load_data;
                if (32'(bus.load_addr) == ptag / 4) pvalid = 0;
            end
            if (e_rdy) begin
                e_rdy = 0; busy = 0; have = 0;
`ifdef CU_IF_PREFETCH_EN
                if (mpc + 4 < BYTES) begin pvalid = 1; ptag = mpc + 4; end
`endif
            end else begin
                if (!busy && bus.memfetch_start) begin
                    if (bus.fetch_pc % 4 != 0) e_mis = 1;
                    else if (bus.fetch_pc >= BYTES) e_rng = 1;
                    else begin
                        busy = 1;
                        mpc  = bus.fetch_pc;
                        due  = cyc + LAT - 1;
`ifdef CU_IF_PREFETCH_EN
                        if (hit) due = cyc;
`endif
                    end
                end
                if (busy && !have && cyc >= due) begin
                    have = 1; e_instr = m[mpc / 4]; e_pc = mpc;
                end
                if (have && !bus.IF_stall) e_rdy = 1;
            end
        end
    end

    always @(negedge soc_clk) begin
        chk("Fetch_ready", 32'(bus.Fetch_ready), 32'(e_rdy));
        chk("fetch_busy", 32'(bus.fetch_busy), 32'(busy));
        chk("misaligned_err", 32'(bus.misaligned_err), 32'(e_mis));
        chk("range_err", 32'(bus.range_err), 32'(e_rng));
        chk("fetch_instr", bus.fetch_instr, e_instr);
        chk("fetch_pc_out", bus.fetch_pc_out, e_pc);
    end

    task automatic load(input logic [6:0] a, input logic [31:0] d);
        bus.load_en = 1; bus.load_addr = a; bus.load_data = d;
        @(negedge soc_clk);
        bus.load_en = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.memfetch_start = 1; bus.fetch_pc = pc;
        @(negedge soc_clk);
        bus.memfetch_start = 0;
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  hold;
        logic [3:0]  stall;
        logic        wr;
    } vec_t;

    vec_t tbl [8];
    int   seen;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h18, 4'd1, 4'd0, 1'b0};
        tbl[1] = '{32'h1C, 4'd1, 4'd0, 1'b1};
        tbl[2] = '{32'h00, 4'd1, 4'd2, 1'b0};
        tbl[3] = '{32'h04, 4'd1, 4'd0, 1'b0};
        tbl[4] = '{32'h200, 4'd1, 4'd0, 1'b0};
        tbl[5] = '{32'h07, 4'd1, 4'd0, 1'b0};
        tbl[6] = '{32'h1FC, 4'd1, 4'd1, 1'b0};
        tbl[7] = '{32'h20, 4'd5, 4'd0, 1'b0};
        bus.memfetch_start = 0; bus.fetch_pc = 0; bus.IF_stall = 0;
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
        repeat (2) @(negedge soc_clk);
        chk("reset busy", 32'(bus.fetch_busy), 0);
        chk("reset instr", bus.fetch_instr, 0);
        reset = 0;
        for (int i = 0; i < DEPTH; i++) load(7'(i), 32'h1000_0000 + 32'(i) * 32'h11);
        load(7'd2, 32'h00A00513);

        // plain fetch: ready only in cycle N+2
        fetch(32'h8);
        chk("t1 ready N+1", 32'(bus.Fetch_ready), 0);
        @(negedge soc_clk);
        chk("t1 ready N+2", 32'(bus.Fetch_ready), 1);
        chk("t1 instr", bus.fetch_instr, 32'h00A00513);
        chk("t1 pc_out", bus.fetch_pc_out, 32'h8);
        @(negedge soc_clk);
        chk("t1 ready N+3", 32'(bus.Fetch_ready), 0);

        // misaligned, out of range, both
        fetch(32'h6);
        chk("t2 mis", 32'(bus.misaligned_err), 1);
        @(negedge soc_clk);
        chk("t2 busy N+2", 32'(bus.fetch_busy), 0);
        chk("t2 ready N+2", 32'(bus.Fetch_ready), 0);
        fetch(32'h200);
        chk("t3 rng", 32'(bus.range_err), 1);
        @(negedge soc_clk);
        chk("t3 rng once", 32'(bus.range_err), 0);
        fetch(32'h203);
        chk("t3 both mis", 32'(bus.misaligned_err), 1);
        chk("t3 both rng", 32'(bus.range_err), 0);
        @(negedge soc_clk);
        fetch(32'h1FC);
        @(negedge soc_clk);
        chk("t3 last ready", 32'(bus.Fetch_ready), 1);
        chk("t3 last instr", bus.fetch_instr, 32'h1000086F);
        @(negedge soc_clk);

        // stall sampled high at edges N+1..N+3: result held, ready in cycle N+5
        fetch(32'h8);
        bus.IF_stall = 1;
        for (int c = 2; c <= 4; c++) begin
            @(negedge soc_clk);
            chk("t4 held ready", 32'(bus.Fetch_ready), 0);
            chk("t4 held instr", bus.fetch_instr, 32'h00A00513);
        end
        bus.IF_stall = 0;
        @(negedge soc_clk);
        chk("t4 ready N+5", 32'(bus.Fetch_ready), 1);
        @(negedge soc_clk);
        chk("t4 ready N+6", 32'(bus.Fetch_ready), 0);

        // reset in the middle of a fetch
        fetch(32'h8);
        #2 reset = 1;
        #1;
        chk("t5 rst busy", 32'(bus.fetch_busy), 0);
        chk("t5 rst instr", bus.fetch_instr, 0);
        chk("t5 rst pc_out", bus.fetch_pc_out, 0);
        @(negedge soc_clk);
        #2 reset = 0;
        seen = 0;
        repeat (4) begin
            @(negedge soc_clk);
            if (bus.Fetch_ready) seen++;
        end
        chk("t5 no ready", 32'(seen), 0);
        fetch(32'h8);
        @(negedge soc_clk);
        chk("t5 refetch ready", 32'(bus.Fetch_ready), 1);
        chk("t5 refetch instr", bus.fetch_instr, 32'h00A00513);
        @(negedge soc_clk);

        // start during WAIT is dropped; then fetch of the next word
        fetch(32'h8);
        bus.memfetch_start = 1; bus.fetch_pc = 32'h10;
        @(negedge soc_clk);
        bus.memfetch_start = 0;
        chk("t6 ready", 32'(bus.Fetch_ready), 1);
        chk("t6 pc_out", bus.fetch_pc_out, 32'h8);
        @(negedge soc_clk);
        chk("t6 idle", 32'(bus.fetch_busy), 0);
        fetch(32'hC);
`ifndef CU_IF_PREFETCH_EN
        chk("t6 next N+1", 32'(bus.Fetch_ready), 0);
        @(negedge soc_clk);
`endif
        chk("t6 next ready", 32'(bus.Fetch_ready), 1);
        chk("t6 next instr", bus.fetch_instr, 32'h10000033);
        chk("t6 next pc_out", bus.fetch_pc_out, 32'hC);
        @(negedge soc_clk);

        // load to the fetched word during WAIT is returned
        fetch(32'h14);
        load(7'd5, 32'hFEED0005);
        chk("t7 ready", 32'(bus.Fetch_ready), 1);
        chk("t7 instr", bus.fetch_instr, 32'hFEED0005);
        @(negedge soc_clk);

        for (int k = 0; k < 8; k++) begin
            if (tbl[k].wr) load(7'(tbl[k].pc / 4), 32'hBEEF0000 + tbl[k].pc);
            bus.memfetch_start = 1;
            bus.fetch_pc = tbl[k].pc;
            bus.IF_stall = tbl[k].stall != 0;
            repeat (int'(tbl[k].hold)) @(negedge soc_clk);
            bus.memfetch_start = 0;
            repeat (int'(tbl[k].stall)) @(negedge soc_clk);
            bus.IF_stall = 0;
            for (int t = 0; t < 30 && bus.fetch_busy; t++) @(negedge soc_clk);
            chk("tbl idle", 32'(bus.fetch_busy), 0);
            @(negedge soc_clk);
        end

        repeat (3) @(negedge soc_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
